// File: rtl/latmon_pkg.sv
// latmon_pkg
// Shared constants and types for the multi-channel latency monitor.
//   LATMON_CNT_W   default timestamp / latency width
//   LATMON_DEPTH   default outstanding starts per channel
//   LATMON_ERR_W   width of the dropped / orphan error counters
//   LATMON_SUM_XW  extra headroom bits of the optional latency accumulator
//   latmon_stats_t per-channel statistics record at the default width
// Optional feature macro: LATMON_SUM_EN (adds the latency accumulator).
package latmon_pkg;

    localparam int LATMON_CNT_W  = 16;
    localparam int LATMON_DEPTH  = 8;
    localparam int LATMON_ERR_W  = 8;
    localparam int LATMON_SUM_XW = 16;

    typedef struct packed {
        logic [LATMON_CNT_W-1:0]               last;
        logic [LATMON_CNT_W-1:0]               min;
        logic [LATMON_CNT_W-1:0]               max;
        logic [LATMON_CNT_W-1:0]               n_samples;
        logic [LATMON_ERR_W-1:0]               n_dropped;
        logic [LATMON_ERR_W-1:0]               n_orphan;
`ifdef LATMON_SUM_EN
        logic [LATMON_CNT_W+LATMON_SUM_XW-1:0] sum;
`endif
    } latmon_stats_t;

endpackage

// File: rtl/latmon_channel.sv
// latmon_channel
// One monitor channel: start/stop edge detection, a timestamp FIFO holding the
// outstanding starts, and the latency statistics of this channel.
// Ports:
//   clk, rst (async, active-low), clear (sync clear of FIFO and stats)
//   start, stop      level inputs, rising edge = one event
//   ts               shared free-running timestamp
//   sample_valid     one-cycle pulse when a latency sample is produced
//   busy             FIFO non-empty
//   lat_last/min/max, n_samples, n_dropped, n_orphan   channel statistics
//   lat_sum          saturating latency accumulator (only with LATMON_SUM_EN)
module latmon_channel
    import latmon_pkg::*;
#(
    parameter int CNT_W = LATMON_CNT_W,
    parameter int DEPTH = LATMON_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    start,
    input  logic                    stop,
    input  logic [CNT_W-1:0]        ts,
    output logic                    sample_valid,
    output logic                    busy,
    output logic [CNT_W-1:0]        lat_last,
    output logic [CNT_W-1:0]        lat_min,
    output logic [CNT_W-1:0]        lat_max,
    output logic [CNT_W-1:0]        n_samples,
    output logic [LATMON_ERR_W-1:0] n_dropped,
    output logic [LATMON_ERR_W-1:0] n_orphan
`ifdef LATMON_SUM_EN
    ,
    output logic [CNT_W+LATMON_SUM_XW-1:0] lat_sum
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic                    start_q_reg, stop_q_reg;
    logic [AW:0]             wr_ptr_reg, rd_ptr_reg;
    logic                    seen_reg;
    logic                    sample_valid_reg;
    logic [CNT_W-1:0]        lat_last_reg, lat_min_reg, lat_max_reg, n_samples_reg;
    logic [LATMON_ERR_W-1:0] n_dropped_reg, n_orphan_reg;
    logic [CNT_W-1:0]        mem [DEPTH];

    logic             start_ev, stop_ev, empty, full;
    logic             push, pop, take, drop_inc, orphan_inc;
    logic [CNT_W-1:0] head, lat;

    always_comb begin
        start_ev   = start & ~start_q_reg;
        stop_ev    = stop & ~stop_q_reg;
        empty      = (wr_ptr_reg == rd_ptr_reg);
        full       = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
        // Shallow FIFO: asynchronous head read so the pop and the latency
        // subtraction complete in the event cycle.
        head       = mem[rd_ptr_reg[AW-1:0]];
        pop        = ~clear & stop_ev & ~empty;
        // A stop meeting a start on an empty FIFO is a zero-latency sample.
        take       = ~clear & stop_ev & (~empty | start_ev);
        // A same-cycle pop frees the slot, so a full FIFO still accepts.
        push       = ~clear & start_ev & ~(stop_ev & empty) & (~full | stop_ev);
        drop_inc   = ~clear & start_ev & full & ~stop_ev;
        orphan_inc = ~clear & stop_ev & empty & ~start_ev;
        lat        = pop ? (ts - head) : '0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= ts;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_q_reg      <= 1'b0;
            stop_q_reg       <= 1'b0;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            seen_reg         <= 1'b0;
            sample_valid_reg <= 1'b0;
            lat_last_reg     <= '0;
            lat_min_reg      <= '0;
            lat_max_reg      <= '0;
            n_samples_reg    <= '0;
            n_dropped_reg    <= '0;
            n_orphan_reg     <= '0;
        end else begin
            // Edge registers keep tracking through clear so no spurious
            // event appears when clear drops.
            start_q_reg <= start;
            stop_q_reg  <= stop;
            if (clear) begin
                wr_ptr_reg       <= '0;
                rd_ptr_reg       <= '0;
                seen_reg         <= 1'b0;
                sample_valid_reg <= 1'b0;
                lat_last_reg     <= '0;
                lat_min_reg      <= '0;
                lat_max_reg      <= '0;
                n_samples_reg    <= '0;
                n_dropped_reg    <= '0;
                n_orphan_reg     <= '0;
            end else begin
                sample_valid_reg <= take;
                if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
                if (drop_inc && (n_dropped_reg != '1)) n_dropped_reg <= n_dropped_reg + 1'b1;
                if (orphan_inc && (n_orphan_reg != '1)) n_orphan_reg <= n_orphan_reg + 1'b1;
                if (take) begin
                    lat_last_reg <= lat;
                    if (!seen_reg || (lat < lat_min_reg)) lat_min_reg <= lat;
                    if (!seen_reg || (lat > lat_max_reg)) lat_max_reg <= lat;
                    seen_reg <= 1'b1;
                    if (n_samples_reg != '1) n_samples_reg <= n_samples_reg + 1'b1;
                end
            end
        end
    end

`ifdef LATMON_SUM_EN
    logic [CNT_W+LATMON_SUM_XW-1:0] lat_sum_reg;
    logic [CNT_W+LATMON_SUM_XW:0]   sum_next;

    always_comb begin
        sum_next = {1'b0, lat_sum_reg} + (CNT_W+LATMON_SUM_XW+1)'(lat);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_sum_reg <= '0;
        end else if (clear) begin
            lat_sum_reg <= '0;
        end else if (take) begin
            lat_sum_reg <= sum_next[CNT_W+LATMON_SUM_XW] ? '1
                                                         : sum_next[CNT_W+LATMON_SUM_XW-1:0];
        end
    end

    assign lat_sum = lat_sum_reg;
`endif

    assign sample_valid = sample_valid_reg;
    assign busy         = ~empty;
    assign lat_last     = lat_last_reg;
    assign lat_min      = lat_min_reg;
    assign lat_max      = lat_max_reg;
    assign n_samples    = n_samples_reg;
    assign n_dropped    = n_dropped_reg;
    assign n_orphan     = n_orphan_reg;

endmodule

// File: rtl/latency_monitor.sv
// latency_monitor
// Multi-channel trigger-to-response latency monitor. Each channel timestamps
// start edges and matches every stop edge to the oldest outstanding start.
// Ports:
//   clk, rst (async, active-low), clear (sync clear of FIFOs and statistics)
//   start[NCH], stop[NCH]   per-channel level inputs, rising edge = event
//   sel                     readback channel select (registered mux, 1 cycle)
//   sample_valid[NCH]       per-channel sample pulse
//   lat_last/min/max, n_samples, n_dropped, n_orphan   stats of channel sel
//   lat_sum                 latency accumulator of channel sel (LATMON_SUM_EN)
//   busy[NCH]               per-channel FIFO non-empty
// Optional feature macro: LATMON_SUM_EN.
module latency_monitor
    import latmon_pkg::*;
#(
    parameter int  NCH   = 4,
    parameter int  CNT_W = LATMON_CNT_W,
    parameter int  DEPTH = LATMON_DEPTH,
    localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic [NCH-1:0]          start,
    input  logic [NCH-1:0]          stop,
    input  logic [SEL_W-1:0]        sel,
    output logic [NCH-1:0]          sample_valid,
    output logic [CNT_W-1:0]        lat_last,
    output logic [CNT_W-1:0]        lat_min,
    output logic [CNT_W-1:0]        lat_max,
    output logic [CNT_W-1:0]        n_samples,
    output logic [LATMON_ERR_W-1:0] n_dropped,
    output logic [LATMON_ERR_W-1:0] n_orphan,
`ifdef LATMON_SUM_EN
    output logic [CNT_W+LATMON_SUM_XW-1:0] lat_sum,
`endif
    output logic [NCH-1:0]          busy
);

    logic [CNT_W-1:0]        ts_reg;
    logic [CNT_W-1:0]        ch_last [NCH];
    logic [CNT_W-1:0]        ch_min [NCH];
    logic [CNT_W-1:0]        ch_max [NCH];
    logic [CNT_W-1:0]        ch_samples [NCH];
    logic [LATMON_ERR_W-1:0] ch_dropped [NCH];
    logic [LATMON_ERR_W-1:0] ch_orphan [NCH];

    // Shared timestamp; clear leaves it running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ts_reg <= '0;
        else      ts_reg <= ts_reg + 1'b1;
    end

`ifdef LATMON_SUM_EN
    logic [CNT_W+LATMON_SUM_XW-1:0] ch_sum [NCH];
    logic [CNT_W+LATMON_SUM_XW-1:0] lat_sum_reg;
`endif

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            latmon_channel #(
                .CNT_W (CNT_W),
                .DEPTH (DEPTH)
            ) u_ch (
                .clk          (clk),
                .rst          (rst),
                .clear        (clear),
                .start        (start[gi]),
                .stop         (stop[gi]),
                .ts           (ts_reg),
                .sample_valid (sample_valid[gi]),
                .busy         (busy[gi]),
                .lat_last     (ch_last[gi]),
                .lat_min      (ch_min[gi]),
                .lat_max      (ch_max[gi]),
                .n_samples    (ch_samples[gi]),
                .n_dropped    (ch_dropped[gi]),
                .n_orphan     (ch_orphan[gi])
`ifdef LATMON_SUM_EN
                ,
                .lat_sum      (ch_sum[gi])
`endif
            );
        end
    endgenerate

    logic [CNT_W-1:0]        lat_last_reg, lat_min_reg, lat_max_reg, n_samples_reg;
    logic [LATMON_ERR_W-1:0] n_dropped_reg, n_orphan_reg;

    // Registered readback; a select beyond NCH (non power-of-two NCH) reads 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_last_reg  <= '0;
            lat_min_reg   <= '0;
            lat_max_reg   <= '0;
            n_samples_reg <= '0;
            n_dropped_reg <= '0;
            n_orphan_reg  <= '0;
`ifdef LATMON_SUM_EN
            lat_sum_reg   <= '0;
`endif
        end else if (int'(sel) < NCH) begin
            lat_last_reg  <= ch_last[sel];
            lat_min_reg   <= ch_min[sel];
            lat_max_reg   <= ch_max[sel];
            n_samples_reg <= ch_samples[sel];
            n_dropped_reg <= ch_dropped[sel];
            n_orphan_reg  <= ch_orphan[sel];
`ifdef LATMON_SUM_EN
            lat_sum_reg   <= ch_sum[sel];
`endif
        end else begin
            lat_last_reg  <= '0;
            lat_min_reg   <= '0;
            lat_max_reg   <= '0;
            n_samples_reg <= '0;
            n_dropped_reg <= '0;
            n_orphan_reg  <= '0;
`ifdef LATMON_SUM_EN
            lat_sum_reg   <= '0;
`endif
        end
    end

    assign lat_last  = lat_last_reg;
    assign lat_min   = lat_min_reg;
    assign lat_max   = lat_max_reg;
    assign n_samples = n_samples_reg;
    assign n_dropped = n_dropped_reg;
    assign n_orphan  = n_orphan_reg;
`ifdef LATMON_SUM_EN
    assign lat_sum   = lat_sum_reg;
`endif

endmodule

// File: doc/latency_monitor.md
# latency_monitor

Multi-channel trigger-to-response latency monitor for the emulation shell. It is the parametrised successor to the single start/stop performance counter. Per channel it timestamps every start edge into a small FIFO, so several triggers can be outstanding at once. Each stop edge is matched to the oldest outstanding start, and the block keeps last/min/max latency plus event and error counters. It sits beside the RD53 emulator on the 40 MHz clock, with start fed by incoming triggers and stop by emulator trigger outputs.

## Interface
- NCH, 4: number of independent channels (1..16)
- CNT_W, 16: timestamp and latency width in bits
- DEPTH, 8: outstanding starts per channel (power of 2, ≥2)
- clk  in  1  monitor clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- clear  in  1  synchronous clear of all FIFOs and statistics
- start  in  NCH  per-channel start level; a rising edge is one event
- stop  in  NCH  per-channel stop level; a rising edge is one event
- sel  in  max(1,$clog2(NCH))  readback channel select
- sample_valid  out  NCH  1-cycle pulse when a channel produces a latency sample
- lat_last  out  CNT_W  last latency of channel sel
- lat_min  out  CNT_W  minimum latency of channel sel
- lat_max  out  CNT_W  maximum latency of channel sel
- n_samples  out  CNT_W  matched start/stop pairs of channel sel, saturating
- n_dropped  out  8  starts lost to a full FIFO on channel sel, saturating
- n_orphan  out  8  stops with no outstanding start on channel sel, saturating
- busy  out  NCH  channel FIFO non-empty

## Operation
- Free-running timestamp counter `ts` is CNT_W wide, wraps modulo 2^CNT_W, and is reset to 0.
- Edge detection: start and stop are registered once. An event occurs when the current value is 1 and the registered value is 0. The registered values reset to 0, so an input held high through reset deasserts gives an event on the first cycle.
- Start event: push `ts` into the channel FIFO. If the FIFO is full, drop the event and increment n_dropped.
- Stop event with FIFO non-empty: pop the head and compute latency = `ts` − head modulo 2^CNT_W. Update lat_last and min/max, increment n_samples, and pulse sample_valid.
- Stop event with FIFO empty: increment n_orphan; no sample is produced.
- Simultaneous start and stop on one channel:
  - FIFO empty: produce a sample of latency 0 and push nothing.
  - Otherwise: pop the head and push the new timestamp in the same cycle. This succeeds even when the FIFO is full, and n_dropped is unchanged.
- First sample after reset or clear loads both min and max. An internal per-channel `seen` flag governs this.
- clear has priority over every event in the same cycle. It empties the FIFOs and zeroes all counters and stats, but does not reset `ts`.
- Latencies of 2^CNT_W cycles or more alias; this is documented behaviour, not an error.
- Reset values: all outputs 0, FIFOs empty, `seen` = 0.

## Timing
- Event on input change at edge t: sampled at t and recognised at t+1, where timestamp = `ts`@t+1.
- Sample: sample_valid is high in the cycle after the stop event. Stats are visible on the readback outputs one cycle later, because the readback mux is registered.
- sel change reaches the readback outputs after 1 cycle.
- Throughput: one start and one stop per channel per cycle; channels are fully independent.
- Reset asserted mid-operation: all state clears immediately and asynchronously. No sample is emitted for in-flight starts.

## Configuration
- LATMON_SUM_EN defined: per channel, a (CNT_W+16)-bit saturating accumulator of latencies, exposed as output `lat_sum` for channel sel. It is cleared by rst and clear and has the same readback timing as the other stats.
- LATMON_SUM_EN undefined: no accumulator and no `lat_sum` port.

## Structure
- Package latmon_pkg: CNT_W default, DEPTH default, error-counter width (8), and a packed struct latmon_stats_t holding last/min/max/n_samples/n_dropped/n_orphan (plus sum under the macro).
- Sub-module latmon_channel contains edge detect, timestamp FIFO, and stats for one channel. The top instantiates NCH copies, the shared `ts`, and the registered readback mux.

## Test plan
- Single pair: start edge at cycle 10, stop edge at cycle 35 on ch0 → sample_valid[0] pulse, lat_last=lat_min=lat_max=25, n_samples=1.
- Pipelined: starts at 0, 5, 10, stops at 20, 22, 40 on ch1 → latencies 20, 17, 30; min=17, max=30, n_samples=3.
- Overflow: DEPTH+2 starts with no stop → n_dropped=2 and busy=1. Then DEPTH stops → DEPTH samples and busy=0.
- Orphan and simultaneous: stop on empty ch2 → n_orphan=1. Start and stop in the same cycle on empty ch2 → sample 0, min=0.
- Wrap: start at `ts`=2^CNT_W−3, stop 10 cycles later → latency 10.
- Clear/reset: clear in the same cycle as a stop with an outstanding start → no sample and all stats 0. Async rst mid-flight → outputs 0 immediately.
